// File: rtl/alu_pkg.sv
// Shared types and constants for the accumulator controller and its 4-bit ALU.
package alu_pkg;

  localparam int DW = 4;

  typedef logic [DW-1:0] data_t;

  typedef enum logic [2:0] {
    OP_LOAD = 3'b000,
    OP_ADD  = 3'b001,
    OP_SUB  = 3'b010,
    OP_OR   = 3'b011,
    OP_AND  = 3'b100,
    OP_MUL  = 3'b101,
    OP_CLR  = 3'b110,
    OP_ILL  = 3'b111
  } op_e;

  localparam logic [1:0] SEL_ADD = 2'b00;
  localparam logic [1:0] SEL_SUB = 2'b01;
  localparam logic [1:0] SEL_OR  = 2'b10;
  localparam logic [1:0] SEL_AND = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_EXEC = 3'd1,
    ST_MUL  = 3'd2,
    ST_NEG  = 3'd3,
    ST_RESP = 3'd4
  } state_e;

  // Magnitude as an unsigned count; -8 maps to 8, which still fits in DW bits.
  function automatic data_t abs_mag(input data_t b);
    return b[DW-1] ? data_t'(~b + 1'b1) : b;
  endfunction

endpackage

// File: rtl/arithmetic_unit.sv
// Combinational 4-bit ALU: wrap-around add/sub with signed overflow, bitwise OR/AND.
module arithmetic_unit
  import alu_pkg::*;
(
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [1:0]    sel,
  output logic [DW-1:0] q,
  output logic          ovf
);

  always_comb begin
    q   = '0;
    ovf = 1'b0;
    case (sel)
      SEL_ADD: begin
        q   = a + b;
        ovf = (a[DW-1] == b[DW-1]) && (q[DW-1] != a[DW-1]);
      end
      SEL_SUB: begin
        q   = a - b;
        ovf = (a[DW-1] != b[DW-1]) && (q[DW-1] != a[DW-1]);
      end
      SEL_OR:  q = a | b;
      default: q = a & b;
    endcase
  end

endmodule

// File: rtl/alu_accumulator.sv
// Command/response accumulator around one arithmetic_unit; MUL runs as repeated adds.
//   state | meaning
//   IDLE  | cmd_ready high, waiting for a command
//   EXEC  | single-step op applied to acc, or MUL set up
//   MUL   | one add of acc into prod per cycle until cnt hits zero
//   NEG   | negate prod for a negative multiplier
//   RESP  | rsp_valid high until rsp_ready
module alu_accumulator
  import alu_pkg::*;
#(
  parameter bit                     MUL_EN  = 1'b1,
  parameter logic signed [DW-1:0]   RST_VAL = 4'sd0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [DW-1:0] cmd_data,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_acc,
  output logic          rsp_ovf,
  output logic          rsp_err,
  output logic          ovf_sticky
);

  state_e        state_q, state_d;
  op_e           op_q, op_d;
  data_t         b_q, b_d;
  data_t         acc_q, acc_d;
  data_t         prod_q, prod_d;
  data_t         cnt_q, cnt_d;
  logic          ovf_early_q, ovf_early_d;
  logic          ovf_last_q, ovf_last_d;
  logic          rsp_ovf_q, rsp_ovf_d;
  logic          rsp_err_q, rsp_err_d;
  logic          sticky_q, sticky_d;

  data_t         alu_a, alu_b, alu_q;
  logic [1:0]    alu_sel;
  logic          alu_ovf;

  arithmetic_unit u_alu (
    .a   (alu_a),
    .b   (alu_b),
    .sel (alu_sel),
    .q   (alu_q),
    .ovf (alu_ovf)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    b_d         = b_q;
    acc_d       = acc_q;
    prod_d      = prod_q;
    cnt_d       = cnt_q;
    ovf_early_d = ovf_early_q;
    ovf_last_d  = ovf_last_q;
    rsp_ovf_d   = rsp_ovf_q;
    rsp_err_d   = rsp_err_q;
    sticky_d    = sticky_q;
    alu_a       = acc_q;
    alu_b       = b_q;
    alu_sel     = SEL_ADD;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d    = op_e'(cmd_op);
          b_d     = cmd_data;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_ovf_d = 1'b0;
        rsp_err_d = 1'b0;
        state_d   = ST_RESP;
        case (op_q)
          OP_LOAD: acc_d = b_q;
          OP_ADD: begin
            alu_sel   = SEL_ADD;
            acc_d     = alu_q;
            rsp_ovf_d = alu_ovf;
          end
          OP_SUB: begin
            alu_sel   = SEL_SUB;
            acc_d     = alu_q;
            rsp_ovf_d = alu_ovf;
          end
          OP_OR: begin
            alu_sel = SEL_OR;
            acc_d   = alu_q;
          end
          OP_AND: begin
            alu_sel = SEL_AND;
            acc_d   = alu_q;
          end
          OP_CLR: begin
            acc_d    = RST_VAL;
            sticky_d = 1'b0;
          end
          OP_MUL: begin
            if (MUL_EN) begin
              prod_d      = '0;
              cnt_d       = abs_mag(b_q);
              ovf_early_d = 1'b0;
              ovf_last_d  = 1'b0;
              state_d     = ST_MUL;
            end else begin
              rsp_err_d = 1'b1;
            end
          end
          default: rsp_err_d = 1'b1;
        endcase
      end
      ST_MUL: begin
        alu_a   = prod_q;
        alu_b   = acc_q;
        alu_sel = SEL_ADD;
        if (cnt_q != '0) begin
          prod_d      = alu_q;
          ovf_early_d = ovf_early_q | ovf_last_q;
          ovf_last_d  = alu_ovf;
          cnt_d       = cnt_q - 4'd1;
        end else if (b_q[DW-1]) begin
          state_d = ST_NEG;
        end else begin
          acc_d     = prod_q;
          rsp_ovf_d = ovf_early_q | ovf_last_q;
          state_d   = ST_RESP;
        end
      end
      ST_NEG: begin
        alu_a   = '0;
        alu_b   = prod_q;
        alu_sel = SEL_SUB;
        acc_d   = alu_q;
        // A partial sum of exactly +8 wraps to -8 on its last add; negating it gives a legal -8.
        rsp_ovf_d = ovf_early_q | (ovf_last_q ? (prod_q != 4'b1000) : alu_ovf);
        state_d   = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_q != ST_RESP && state_d == ST_RESP) sticky_d = sticky_d | rsp_ovf_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_LOAD;
      b_q         <= '0;
      acc_q       <= RST_VAL;
      prod_q      <= '0;
      cnt_q       <= '0;
      ovf_early_q <= 1'b0;
      ovf_last_q  <= 1'b0;
      rsp_ovf_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      prod_q      <= prod_d;
      cnt_q       <= cnt_d;
      ovf_early_q <= ovf_early_d;
      ovf_last_q  <= ovf_last_d;
      rsp_ovf_q   <= rsp_ovf_d;
      rsp_err_q   <= rsp_err_d;
      sticky_q    <= sticky_d;
    end
  end

  assign cmd_ready  = (state_q == ST_IDLE);
  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_acc    = acc_q;
  assign rsp_ovf    = rsp_ovf_q;
  assign rsp_err    = rsp_err_q;
  assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_alu_accumulator.sv
// Self-checking bench for alu_accumulator: vector table, hand sequences, random ops vs model.
module tb_alu_accumulator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0, cmd_ready;
  logic [2:0] cmd_op = 3'd0;
  logic [3:0] cmd_data = 4'd0;
  logic       rsp_valid, rsp_ready = 1'b0;
  logic [3:0] rsp_acc;
  logic       rsp_ovf, rsp_err, ovf_sticky;

  logic       v2 = 1'b0, rdy2;
  logic [2:0] op2 = 3'd0;
  logic [3:0] d2 = 4'd0;
  logic       rv2, rr2 = 1'b0;
  logic [3:0] acc2;
  logic       ovf2, err2, st2;

  int total = 0;
  int bad = 0;
  int acc_m = 0;
  int sticky_m = 0;

  always #5 clk = ~clk;

  alu_accumulator #(.MUL_EN(1'b1), .RST_VAL(4'sd0)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_acc(rsp_acc), .rsp_ovf(rsp_ovf), .rsp_err(rsp_err), .ovf_sticky(ovf_sticky)
  );

  alu_accumulator #(.MUL_EN(1'b0), .RST_VAL(4'sd0)) dut_nomul (
    .clk(clk), .rst_n(rst_n), .cmd_valid(v2), .cmd_ready(rdy2),
    .cmd_op(op2), .cmd_data(d2), .rsp_valid(rv2), .rsp_ready(rr2),
    .rsp_acc(acc2), .rsp_ovf(ovf2), .rsp_err(err2), .ovf_sticky(st2)
  );

  typedef struct {
    logic [2:0] op;
    logic [3:0] d;
    int         acc;
    int         ovf;
    int         err;
    int         sticky;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int wrap4(input int v);
    int r;
    r = v & 15;
    return (r > 7) ? r - 16 : r;
  endfunction

  function automatic int mul_latency(input logic [3:0] d);
    int b;
    b = $signed(d);
    return (b < 0) ? 3 - b : 2 + b;
  endfunction

  // Reference: plain signed integer arithmetic, overflow = true result out of [-8, 7].
  task automatic model(input logic [2:0] op, input logic [3:0] d,
                       output int e_acc, output int e_ovf, output int e_err);
    int b, r;
    b = $signed(d);
    r = acc_m;
    e_ovf = 0;
    e_err = 0;
    case (op)
      3'd0: r = b;
      3'd1: r = acc_m + b;
      3'd2: r = acc_m - b;
      3'd3: r = acc_m | b;
      3'd4: r = acc_m & b;
      3'd5: r = acc_m * b;
      3'd6: begin r = 0; sticky_m = 0; end
      default: e_err = 1;
    endcase
    if (op == 3'd1 || op == 3'd2 || op == 3'd5) e_ovf = (r < -8 || r > 7) ? 1 : 0;
    acc_m = wrap4(r);
    sticky_m = sticky_m | e_ovf;
    e_acc = acc_m;
  endtask

  task automatic do_cmd(input logic [2:0] op, input logic [3:0] d,
                        output int acc, output int ovf, output int err, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
    while (!cmd_ready && guard < 50) begin @(negedge clk); guard++; end
    chk("cmd_ready_wait", int'(cmd_ready), 1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 40) begin @(negedge clk); lat++; end
    chk("rsp_valid_wait", int'(rsp_valid), 1);
    acc = $signed(rsp_acc);
    ovf = rsp_ovf;
    err = rsp_err;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic do_cmd2(input logic [2:0] op, input logic [3:0] d,
                         output int acc, output int ovf, output int err);
    int guard;
    guard = 0;
    @(negedge clk);
    v2 = 1'b1; op2 = op; d2 = d;
    @(posedge clk);
    @(negedge clk);
    v2 = 1'b0;
    while (!rv2 && guard < 40) begin @(negedge clk); guard++; end
    chk("nomul_rsp_wait", int'(rv2), 1);
    acc = $signed(acc2);
    ovf = ovf2;
    err = err2;
    rr2 = 1'b1;
    @(negedge clk);
    rr2 = 1'b0;
  endtask

  initial begin
    vec_t vecs[$];
    int a, o, e, lat, ea, eo, ee, held;
    logic [2:0] rop;
    logic [3:0] rd;

    vecs.push_back('{3'd0, 4'h3,  3, 0, 0, 0});
    vecs.push_back('{3'd1, 4'h4,  7, 0, 0, 0});
    vecs.push_back('{3'd1, 4'h1, -8, 1, 0, 1});
    vecs.push_back('{3'd0, 4'h8, -8, 0, 0, 1});
    vecs.push_back('{3'd2, 4'h1,  7, 1, 0, 1});
    vecs.push_back('{3'd6, 4'h0,  0, 0, 0, 0});
    vecs.push_back('{3'd0, 4'h3,  3, 0, 0, 0});
    vecs.push_back('{3'd5, 4'hE, -6, 0, 0, 0});
    vecs.push_back('{3'd0, 4'h3,  3, 0, 0, 0});
    vecs.push_back('{3'd5, 4'h3, -7, 1, 0, 1});
    vecs.push_back('{3'd0, 4'h8, -8, 0, 0, 1});
    vecs.push_back('{3'd5, 4'hF, -8, 1, 0, 1});
    vecs.push_back('{3'd7, 4'h5, -8, 0, 1, 1});
    vecs.push_back('{3'd0, 4'h5,  5, 0, 0, 1});
    vecs.push_back('{3'd3, 4'h2,  7, 0, 0, 1});
    vecs.push_back('{3'd4, 4'h3,  3, 0, 0, 1});
    vecs.push_back('{3'd5, 4'h0,  0, 0, 0, 1});
    vecs.push_back('{3'd6, 4'h0,  0, 0, 0, 0});
    vecs.push_back('{3'd5, 4'hB,  0, 0, 0, 0});
    vecs.push_back('{3'd0, 4'h4,  4, 0, 0, 0});
    vecs.push_back('{3'd5, 4'hE, -8, 0, 0, 0});
    vecs.push_back('{3'd0, 4'hF, -1, 0, 0, 0});
    vecs.push_back('{3'd5, 4'h8, -8, 1, 0, 1});

    repeat (3) @(negedge clk);
    chk("reset_cmd_ready", int'(cmd_ready), 1);
    chk("reset_rsp_valid", int'(rsp_valid), 0);
    chk("reset_rsp_acc", int'($signed(rsp_acc)), 0);
    chk("reset_rsp_ovf", int'(rsp_ovf), 0);
    chk("reset_rsp_err", int'(rsp_err), 0);
    chk("reset_sticky", int'(ovf_sticky), 0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      do_cmd(vecs[i].op, vecs[i].d, a, o, e, lat);
      model(vecs[i].op, vecs[i].d, ea, eo, ee);
      chk($sformatf("vec%0d_acc", i), a, vecs[i].acc);
      chk($sformatf("vec%0d_ovf", i), o, vecs[i].ovf);
      chk($sformatf("vec%0d_err", i), e, vecs[i].err);
      chk($sformatf("vec%0d_sticky", i), int'(ovf_sticky), vecs[i].sticky);
      if (vecs[i].op == 3'd5) chk($sformatf("vec%0d_mul_latency", i), lat, mul_latency(vecs[i].d));
    end

    // Response held off for 5 cycles with a stray command pulse in the window.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd0; cmd_data = 4'h6;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    held = 0;
    while (!rsp_valid && held < 40) begin @(negedge clk); held++; end
    chk("stall_rsp_valid_wait", int'(rsp_valid), 1);
    model(3'd0, 4'h6, ea, eo, ee);
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin cmd_valid = 1'b1; cmd_op = 3'd1; cmd_data = 4'h1; end
      if (k == 3) cmd_valid = 1'b0;
      chk($sformatf("stall%0d_rsp_valid", k), int'(rsp_valid), 1);
      chk($sformatf("stall%0d_rsp_acc", k), int'($signed(rsp_acc)), 6);
      chk($sformatf("stall%0d_rsp_ovf", k), int'(rsp_ovf), 0);
      chk($sformatf("stall%0d_cmd_ready", k), int'(cmd_ready), 0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("stall_done_rsp_valid", int'(rsp_valid), 0);
    do_cmd(3'd1, 4'h0, a, o, e, lat);
    model(3'd1, 4'h0, ea, eo, ee);
    chk("stall_pulse_ignored_acc", a, 6);

    // Reset in the middle of a multiply.
    do_cmd(3'd0, 4'h2, a, o, e, lat);
    model(3'd0, 4'h2, ea, eo, ee);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd5; cmd_data = 4'h7;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midmul_rst_rsp_valid", int'(rsp_valid), 0);
    chk("midmul_rst_acc", int'($signed(rsp_acc)), 0);
    chk("midmul_rst_cmd_ready", int'(cmd_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    acc_m = 0;
    sticky_m = 0;
    do_cmd(3'd1, 4'h1, a, o, e, lat);
    model(3'd1, 4'h1, ea, eo, ee);
    chk("after_rst_add_acc", a, 1);

    // Randomized ops against the integer reference model.
    for (int n = 0; n < 80; n++) begin
      rop = 3'($urandom_range(0, 7));
      rd  = 4'($urandom);
      do_cmd(rop, rd, a, o, e, lat);
      model(rop, rd, ea, eo, ee);
      chk($sformatf("rnd%0d_op%0d_acc", n, rop), a, ea);
      chk($sformatf("rnd%0d_op%0d_ovf", n, rop), o, eo);
      chk($sformatf("rnd%0d_op%0d_err", n, rop), e, ee);
      chk($sformatf("rnd%0d_sticky", n), int'(ovf_sticky), sticky_m);
      if (rop == 3'd5) chk($sformatf("rnd%0d_mul_latency", n), lat, mul_latency(rd));
    end

    // MUL rejected when the multiplier is disabled.
    do_cmd2(3'd0, 4'h5, a, o, e);
    chk("nomul_load_acc", a, 5);
    do_cmd2(3'd5, 4'h2, a, o, e);
    chk("nomul_mul_err", e, 1);
    chk("nomul_mul_acc", a, 5);
    chk("nomul_mul_ovf", o, 0);
    do_cmd2(3'd1, 4'h1, a, o, e);
    chk("nomul_add_acc", a, 6);
    chk("nomul_add_err", e, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
